// File: rtl/regfile_decode_param_pkg.sv
// Shared constants for the decode-stage register file.
//   - instruction codes HALT..POPQ as seen by the decode stage
//   - REG_NONE, the "no register" specifier
//   - default register/data width
//   - idx_valid(): true when a 4-bit specifier names a real register
package regfile_decode_param_pkg;

    localparam int DATA_W_DEFAULT = 64;

    localparam logic [3:0] REG_NONE = 4'hF;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // REG_NONE is always >= nregs (nregs <= 15), so one compare covers both cases.
    function automatic logic idx_valid(input logic [3:0] idx, input int nregs);
        return (int'(idx) < nregs);
    endfunction

endpackage

// File: rtl/regfile_decode_src_select.sv
// Source-register selection for the decode stage.
// Ports:
//   icode       in   instruction code
//   rA, rB      in   register specifiers from the instruction
//   srcA, srcB  out  register indices to read (REG_NONE when unused)
// Purely combinational.
module src_select
    import regfile_decode_param_pkg::*;
#(
    parameter int RSP_IDX = 4
) (
    input  logic [3:0] icode,
    input  logic [3:0] rA,
    input  logic [3:0] rB,
    output logic [3:0] srcA,
    output logic [3:0] srcB
);

    localparam logic [3:0] RSP = 4'(RSP_IDX);

    always_comb begin
        srcA = REG_NONE;
        case (icode)
            I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: srcA = rA;
            I_RET, I_POPQ:                      srcA = RSP;
            default:                            srcA = REG_NONE;
        endcase
    end

    always_comb begin
        srcB = REG_NONE;
        case (icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ:          srcB = rB;
            I_CALL, I_RET, I_PUSHQ, I_POPQ:     srcB = RSP;
            default:                            srcB = REG_NONE;
        endcase
    end

endmodule

// File: rtl/regfile_decode_param.sv
// Decode-stage register file with two read ports and two write ports.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   icode, rA, rB       instruction fields in decode
//   wr_en               write-back enable
//   dstE/valE           execute write-back (REG_NONE = no write)
//   dstM/valM           memory write-back (wins over dstE on a tie)
//   srcA, srcB          decoded source indices
//   valA, valB          operands, optionally forwarded from this cycle's write-back
//   reg_dump            stored register contents, register i at [i*DATA_W +: DATA_W]
module regfile_decode_param
    import regfile_decode_param_pkg::*;
#(
    parameter int                DATA_W   = DATA_W_DEFAULT,
    parameter int                NREGS    = 15,
    parameter int                RSP_IDX  = 4,
    parameter logic [DATA_W-1:0] RSP_INIT = '0,
    parameter int                BYPASS   = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [3:0]              icode,
    input  logic [3:0]              rA,
    input  logic [3:0]              rB,
    input  logic                    wr_en,
    input  logic [3:0]              dstE,
    input  logic [DATA_W-1:0]       valE,
    input  logic [3:0]              dstM,
    input  logic [DATA_W-1:0]       valM,
    output logic [3:0]              srcA,
    output logic [3:0]              srcB,
    output logic [DATA_W-1:0]       valA,
    output logic [DATA_W-1:0]       valB,
    output logic [NREGS*DATA_W-1:0] reg_dump
);

    logic              dst_e_ok;
    logic              dst_m_ok;
    logic              byp_live;
    logic [DATA_W-1:0] rd_view [16];

    src_select #(.RSP_IDX(RSP_IDX)) u_src_select (
        .icode (icode),
        .rA    (rA),
        .rB    (rB),
        .srcA  (srcA),
        .srcB  (srcB)
    );

    assign dst_e_ok = idx_valid(dstE, NREGS);
    assign dst_m_ok = idx_valid(dstM, NREGS);

    // Forwarding is gated by rst_n so a write that reset is about to discard
    // never leaks onto the operand buses.
    assign byp_live = (BYPASS != 0) && rst_n && wr_en;

    for (genvar g = 0; g < 16; g++) begin : g_reg
        if (g < NREGS) begin : g_live
            localparam logic [DATA_W-1:0] RST_VAL = (g == RSP_IDX) ? RSP_INIT : '0;
            logic [DATA_W-1:0] q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q <= RST_VAL;
                end else if (wr_en && dst_m_ok && (dstM == 4'(g))) begin
                    q <= valM;
                end else if (wr_en && dst_e_ok && (dstE == 4'(g))) begin
                    q <= valE;
                end
            end

            assign rd_view[g]                      = q;
            assign reg_dump[g*DATA_W +: DATA_W]    = q;
        end else begin : g_none
            // Unimplemented indices (including REG_NONE) read as zero.
            assign rd_view[g] = '0;
        end
    end

    always_comb begin
        valA = rd_view[srcA];
        if (byp_live && dst_m_ok && (dstM == srcA)) begin
            valA = valM;
        end else if (byp_live && dst_e_ok && (dstE == srcA)) begin
            valA = valE;
        end
    end

    always_comb begin
        valB = rd_view[srcB];
        if (byp_live && dst_m_ok && (dstM == srcB)) begin
            valB = valM;
        end else if (byp_live && dst_e_ok && (dstE == srcB)) begin
            valB = valE;
        end
    end

endmodule

// File: tb/tb_regfile_decode_param.sv
// Bench for regfile_decode_param: two instances (15 regs with forwarding,
// 8 regs without) share one stimulus stream and are checked every cycle
// against an array model, plus a set of hand-computed directed checks.
module tb_regfile_decode_param;
    import regfile_decode_param_pkg::*;

    localparam int          DW      = 64;
    localparam logic [63:0] SP_INIT = 64'h100;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  icode = 4'h1;
    logic [3:0]  rA    = 4'h0;
    logic [3:0]  rB    = 4'h0;
    logic        wr_en = 1'b0;
    logic [3:0]  dstE  = 4'hF;
    logic [3:0]  dstM  = 4'hF;
    logic [63:0] valE  = '0;
    logic [63:0] valM  = '0;

    logic [3:0]       srca0, srcb0, srca1, srcb1;
    logic [63:0]      vala0, valb0, vala1, valb1;
    logic [15*DW-1:0] dump0;
    logic [8*DW-1:0]  dump1;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    logic [63:0] m [2][16];
    int nregs_p [2] = '{15, 8};
    int byp_p   [2] = '{1, 0};

    always #5 clk = ~clk;

    regfile_decode_param #(.DATA_W(DW), .NREGS(15), .RSP_IDX(4), .RSP_INIT(SP_INIT), .BYPASS(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .icode(icode), .rA(rA), .rB(rB), .wr_en(wr_en),
        .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
        .srcA(srca0), .srcB(srcb0), .valA(vala0), .valB(valb0), .reg_dump(dump0)
    );

    regfile_decode_param #(.DATA_W(DW), .NREGS(8), .RSP_IDX(4), .RSP_INIT(SP_INIT), .BYPASS(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .icode(icode), .rA(rA), .rB(rB), .wr_en(wr_en),
        .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
        .srcA(srca1), .srcB(srcb1), .valA(vala1), .valB(valb1), .reg_dump(dump1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: actual %h required %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [3:0] exp_srca(input logic [3:0] ic, input logic [3:0] ra);
        if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
        if (ic inside {4'h9, 4'hB}) return 4'd4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] exp_srcb(input logic [3:0] ic, input logic [3:0] rb);
        if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'd4;
        return 4'hF;
    endfunction

    function automatic logic [63:0] stored(input int k, input int i);
        if (i >= nregs_p[k]) return '0;
        if (!rst_n) return (i == 4) ? SP_INIT : 64'h0;
        return m[k][i];
    endfunction

    function automatic logic [63:0] exp_read(input int k, input int idx);
        if (idx >= nregs_p[k]) return '0;
        if (byp_p[k] != 0 && rst_n && wr_en) begin
            if (int'(dstM) == idx) return valM;
            if (int'(dstE) == idx) return valE;
        end
        return stored(k, idx);
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 16; i++)
                m[k][i] = (i == 4) ? SP_INIT : 64'h0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else if (wr_en) begin
            for (int k = 0; k < 2; k++) begin
                if (int'(dstE) < nregs_p[k]) m[k][dstE] = valE;
                if (int'(dstM) < nregs_p[k]) m[k][dstM] = valM;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("srcA0", {60'h0, srca0}, {60'h0, exp_srca(icode, rA)});
            check("srcB0", {60'h0, srcb0}, {60'h0, exp_srcb(icode, rB)});
            check("srcA1", {60'h0, srca1}, {60'h0, exp_srca(icode, rA)});
            check("srcB1", {60'h0, srcb1}, {60'h0, exp_srcb(icode, rB)});
            check("valA0", vala0, exp_read(0, int'(exp_srca(icode, rA))));
            check("valB0", valb0, exp_read(0, int'(exp_srcb(icode, rB))));
            check("valA1", vala1, exp_read(1, int'(exp_srca(icode, rA))));
            check("valB1", valb1, exp_read(1, int'(exp_srcb(icode, rB))));
            for (int i = 0; i < 15; i++)
                check($sformatf("dump0[%0d]", i), dump0[i*DW +: DW], stored(0, i));
            for (int i = 0; i < 8; i++)
                check($sformatf("dump1[%0d]", i), dump1[i*DW +: DW], stored(1, i));
        end
    end

    task automatic drive(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                         input logic we, input logic [3:0] de, input logic [63:0] ve,
                         input logic [3:0] dm, input logic [63:0] vm);
        @(posedge clk);
        #1;
        icode = ic; rA = ra; rB = rb; wr_en = we;
        dstE = de; valE = ve; dstM = dm; valM = vm;
    endtask

    initial begin
        model_reset();
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        icode = 4'hA; rA = 4'd2; rB = 4'd0;
        @(negedge clk);
        check("lit_push_srcA", {60'h0, srca0}, 64'd2);
        check("lit_push_srcB", {60'h0, srcb0}, 64'd4);
        check("lit_push_valA", vala0, 64'h0);
        check("lit_push_valB", valb0, 64'h100);
        check("lit_push_valB_n8", valb1, 64'h100);

        drive(4'h6, 4'd3, 4'd0, 1'b1, 4'd3, 64'h55, 4'hF, 64'h0);
        @(negedge clk);
        check("lit_bypass_on", vala0, 64'h55);
        check("lit_bypass_off", vala1, 64'h0);
        drive(4'h6, 4'd3, 4'd0, 1'b0, 4'hF, 64'h0, 4'hF, 64'h0);
        @(negedge clk);
        check("lit_after_on", vala0, 64'h55);
        check("lit_after_off", vala1, 64'h55);

        drive(4'h1, 4'd0, 4'd0, 1'b1, 4'd4, 64'h108, 4'd4, 64'h77);
        drive(4'h1, 4'd0, 4'd0, 1'b0, 4'hF, 64'h0, 4'hF, 64'h0);
        @(negedge clk);
        check("lit_m_wins0", dump0[4*DW +: DW], 64'h77);
        check("lit_m_wins1", dump1[4*DW +: DW], 64'h77);

        drive(4'h3, 4'd5, 4'd6, 1'b0, 4'hF, 64'h0, 4'hF, 64'h0);
        @(negedge clk);
        check("lit_irmov_srcA", {60'h0, srca0}, 64'hF);
        check("lit_irmov_srcB", {60'h0, srcb0}, 64'hF);
        check("lit_irmov_valA", vala0, 64'h0);
        check("lit_irmov_valB", valb0, 64'h0);

        drive(4'h1, 4'd0, 4'd0, 1'b1, 4'hF, 64'h123, 4'hF, 64'h456);
        drive(4'h1, 4'd0, 4'd0, 1'b1, 4'd14, 64'h999, 4'hF, 64'h0);
        drive(4'h1, 4'd0, 4'd0, 1'b0, 4'hF, 64'h0, 4'hF, 64'h0);
        @(negedge clk);
        check("lit_r14_n15", dump0[14*DW +: DW], 64'h999);
        for (int i = 0; i < 8; i++)
            check($sformatf("lit_n8_dump[%0d]", i), dump1[i*DW +: DW],
                  (i == 3) ? 64'h55 : (i == 4) ? 64'h77 : 64'h0);

        drive(4'h2, 4'd1, 4'd0, 1'b1, 4'd1, 64'hAA, 4'hF, 64'h0);
        drive(4'h2, 4'd1, 4'd0, 1'b1, 4'd1, 64'hBB, 4'hF, 64'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("lit_rst_valA0", vala0, 64'h0);
        check("lit_rst_valA1", vala1, 64'h0);
        check("lit_rst_r1", dump0[1*DW +: DW], 64'h0);
        check("lit_rst_sp", dump0[4*DW +: DW], 64'h100);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wr_en = 1'b0;
        @(negedge clk);
        check("lit_lost_write", dump0[1*DW +: DW], 64'h0);
        check("lit_lost_valA", vala0, 64'h0);

        for (int n = 0; n < 600; n++) begin
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            icode = 4'($urandom_range(0, 15));
            rA    = 4'($urandom_range(0, 15));
            rB    = 4'($urandom_range(0, 15));
            wr_en = ($urandom_range(0, 3) != 0);
            dstE  = 4'($urandom_range(0, 15));
            dstM  = ($urandom_range(0, 3) == 0) ? dstE : 4'($urandom_range(0, 15));
            valE  = {$urandom, $urandom};
            valM  = {$urandom, $urandom};
            if ($urandom_range(0, 79) == 0) begin
                #2;
                rst_n = 1'b0;
            end
        end

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wr_en = 1'b0;
        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
